hwpe_stream_source_realigner: RTL and testbench
===============================================

# hwpe_stream_source_realigner

Streaming realigner between a memory-side HWPE stream source and an accelerator datapath. It turns a sequence of word-aligned input words into an aligned output stream. The requested data starts at byte offset `R` inside the first input word. Each output word is built from the upper `NB-R` bytes of the held previous word and the lower `R` bytes of the current input word, so that `len` fully-aligned words appear on `pop_o`. It performs the read-side inverse of the strobe-based sink realignment and sits between a source/TCDM adapter and the engine.

## Interface
- `DATA_WIDTH`, default 32: stream width; must be a multiple of 8 and at least 16. `NB = DATA_WIDTH/8`.
- `LEN_WIDTH`, default 16: width of the transfer-length counter.
- `clk_i`, input, 1: clock.
- `rst_i`, input, 1: asynchronous, active-high reset.
- `clear_i`, input, 1: synchronous soft clear; returns the block to IDLE and zeroes the hold register and counter.
- `ctrl_start_i`, input, 1: start pulse; sampled only in IDLE.
- `ctrl_offset_i`, input, `$clog2(NB)`: byte offset `R` of the first useful byte.
- `ctrl_len_i`, input, `LEN_WIDTH`: number of output words to produce.
- `flags_busy_o`, output, 1: high in every state except IDLE.
- `flags_done_o`, output, 1: one-cycle pulse when a transfer ends.
- `push_i`, `hwpe_stream_intf_stream.sink`, `DATA_WIDTH`: input words; `push_i.strb` is ignored.
- `pop_o`, `hwpe_stream_intf_stream.source`, `DATA_WIDTH`: aligned output; `pop_o.strb` is all ones.

## Operation
- The FSM has four states: IDLE, PASS, PRIME, STREAM. `offset_q`, `len_q`, `cnt_q` and `hold_q[DATA_WIDTH]` are all registered.
- **IDLE**
  - `push_i.ready=0`, `pop_o.valid=0`.
  - On `ctrl_start_i`, latch the offset and length and clear `cnt_q`.
  - If `len==0`: stay in IDLE and pulse `flags_done_o` on the next cycle.
  - Else if `R==0`: go to PASS.
  - Otherwise: go to PRIME.
- **PASS**
  - Combinational pass-through: `pop_o.valid=push_i.valid`, `pop_o.data=push_i.data`, `push_i.ready=pop_o.ready`.
  - Each handshake does `cnt_q++`.
  - On the handshake where `cnt_q==len_q-1`, go to IDLE and pulse done.
  - Consumes exactly `len` input words.
- **PRIME**
  - `push_i.ready=1` and `pop_o.valid=0`.
  - On the input handshake, `hold_q<=push_i.data` and go to STREAM.
- **STREAM**
  - `pop_o.valid=push_i.valid` and `push_i.ready=pop_o.ready`.
  - Output byte `i`: for `i<NB-R` it is `hold_q` byte `R+i`; otherwise it is `push_i.data` byte `i-(NB-R)`.
  - On each handshake: `hold_q<=push_i.data`, `cnt_q++`.
  - On the handshake where `cnt_q==len_q-1`, go to IDLE and pulse done.
  - Bytes `R..NB-1` of the final input word are discarded.
  - Consumes exactly `len+1` input words.
- Byte order is little-endian: byte `k` occupies bits `[8k+7:8k]`.
- `pop_o.valid` never depends on `pop_o.ready` within a cycle. Once `pop_o.valid` is asserted, data stays stable until the handshake, because `push_i` obeys the same rule.
- `ctrl_start_i` outside IDLE is ignored; there is no queuing.
- `clear_i` has priority over all state updates. Asserting `clear_i` together with `ctrl_start_i` means the start is ignored.

## Timing
- Reset values:
  - state = IDLE.
  - `hold_q`, `cnt_q`, `len_q`, `offset_q` = 0.
  - `pop_o.valid=0`, `push_i.ready=0`, `flags_busy_o=0`, `flags_done_o=0`.
  - `pop_o.data`: 0 while in IDLE.
- Reset asserted mid-transfer aborts immediately. No done pulse is generated and any partial data is lost.
- Latency:
  - PASS and STREAM add zero cycles of data latency (combinational path).
  - PRIME adds at least one cycle before the first output.
- Start-to-first-output:
  - PASS: at least 1 cycle after the start cycle.
  - PRIME/STREAM: at least 2 cycles.
- `flags_done_o` is registered: it is high for the single cycle after the final handshake, which is also the first IDLE cycle.
- `flags_busy_o` drops in that same cycle.
- A new start may be issued in the cycle in which `flags_done_o` is high.
- The counter never wraps: the maximum `len` is `2^LEN_WIDTH-1`.

## Test plan
- Offset 0, len 3, inputs `0xA0`, `0xA1`, `0xA2` → 3 identical outputs; 3 input handshakes; done pulses once after the third.
- Offset 1, len 2, inputs `0x33221100`, `0x77665544`, `0xBBAA9988` → outputs `0x44332211`, `0x88776655`; 3 input handshakes; `pop_o.strb=0xF`.
- Offset 3, len 16, random valid/ready stalls with probability 0.2 on both sides → output stream equals the input byte stream shifted by 3 bytes; no drop or duplicate; data stable while stalled.
- `ctrl_len_i=0`, any offset → no handshakes; `flags_done_o` high exactly one cycle later; busy stays 0.
- `rst_i` asserted for 1 cycle mid-STREAM (after 2 of 5 outputs) → asynchronous return to IDLE with all outputs 0. A following start with offset 2, len 1 produces the correct single word.
- `ctrl_start_i` pulsed while busy → ignored; transfer length unchanged. `clear_i` during PRIME → IDLE next cycle, no done pulse.

Source files
------------

// File: rtl/hwpe_stream_source_realigner.sv
// Read-side stream realigner: drops the first R bytes of a word-aligned
// input stream and emits len fully-aligned words. Each output word joins the
// upper NB-R bytes of the held previous input word with the lower R bytes of
// the current input word.
module hwpe_stream_source_realigner #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned LEN_WIDTH  = 16,
  localparam int unsigned NB = DATA_WIDTH / 8,
  localparam int unsigned OW = $clog2(NB)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  clear_i,
  input  logic                  ctrl_start_i,
  input  logic [OW-1:0]         ctrl_offset_i,
  input  logic [LEN_WIDTH-1:0]  ctrl_len_i,
  output logic                  flags_busy_o,
  output logic                  flags_done_o,
  input  logic                  push_valid_i,
  output logic                  push_ready_o,
  input  logic [DATA_WIDTH-1:0] push_data_i,
  input  logic [NB-1:0]         push_strb_i,
  output logic                  pop_valid_o,
  input  logic                  pop_ready_i,
  output logic [DATA_WIDTH-1:0] pop_data_o,
  output logic [NB-1:0]         pop_strb_o
);

  localparam int unsigned IW = $clog2(2 * NB);

  typedef enum logic [1:0] {IDLE, PASS, PRIME, STREAM} state_t;

  state_t                  state_q, state_d;
  logic [OW-1:0]           offset_q;
  logic [LEN_WIDTH-1:0]    len_q;
  logic [LEN_WIDTH-1:0]    cnt_q;
  logic [DATA_WIDTH-1:0]   hold_q;
  logic                    done_q;

  logic                    advance;    // an output word was handed over
  logic                    hold_load;  // capture the current input word
  logic                    last_word;
  logic [DATA_WIDTH-1:0]   aligned;
  logic [7:0]              cat_bytes [2*NB];
  logic                    unused_strb;

  // Input strobes carry no information for a realigned read stream.
  assign unused_strb = ^push_strb_i;

  // Byte window over {current input, held word}; output byte i is window byte R+i.
  genvar gi;
  for (gi = 0; gi < NB; gi++) begin : g_bytes
    assign cat_bytes[gi]                = hold_q[8*gi +: 8];
    assign cat_bytes[NB+gi]             = push_data_i[8*gi +: 8];
    assign aligned[8*gi +: 8]           = cat_bytes[IW'(gi) + IW'(offset_q)];
  end

  assign last_word    = (cnt_q == len_q - LEN_WIDTH'(1));
  assign flags_busy_o = (state_q != IDLE);
  assign flags_done_o = done_q;
  assign pop_strb_o   = '1;

  // Next-state and handshake steering; clear overrides any transition.
  always_comb begin
    state_d      = state_q;
    push_ready_o = 1'b0;
    pop_valid_o  = 1'b0;
    pop_data_o   = '0;
    advance      = 1'b0;
    hold_load    = 1'b0;
    case (state_q)
      IDLE: begin
        if (ctrl_start_i && (ctrl_len_i != '0)) begin
          state_d = (ctrl_offset_i == '0) ? PASS : PRIME;
        end
      end
      PASS: begin
        pop_valid_o  = push_valid_i;
        pop_data_o   = push_data_i;
        push_ready_o = pop_ready_i;
        if (push_valid_i && pop_ready_i) begin
          advance = 1'b1;
          if (last_word) state_d = IDLE;
        end
      end
      PRIME: begin
        push_ready_o = 1'b1;
        if (push_valid_i) begin
          hold_load = 1'b1;
          state_d   = STREAM;
        end
      end
      STREAM: begin
        pop_valid_o  = push_valid_i;
        pop_data_o   = aligned;
        push_ready_o = pop_ready_i;
        if (push_valid_i && pop_ready_i) begin
          advance   = 1'b1;
          hold_load = 1'b1;
          if (last_word) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (clear_i) state_d = IDLE;
  end

  // State, transfer parameters, hold word and registered done pulse.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      offset_q <= '0;
      len_q    <= '0;
      cnt_q    <= '0;
      hold_q   <= '0;
      done_q   <= 1'b0;
    end else if (clear_i) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      hold_q   <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= 1'b0;
      if ((state_q == IDLE) && ctrl_start_i) begin
        offset_q <= ctrl_offset_i;
        len_q    <= ctrl_len_i;
        cnt_q    <= '0;
        // A zero-length request completes without ever leaving IDLE.
        if (ctrl_len_i == '0) done_q <= 1'b1;
      end
      if (advance) begin
        cnt_q <= cnt_q + LEN_WIDTH'(1);
        if (last_word) done_q <= 1'b1;
      end
      if (hold_load) hold_q <= push_data_i;
    end
  end

endmodule

// File: tb/tb_hwpe_stream_source_realigner.sv
// Directed bench for hwpe_stream_source_realigner (DATA_WIDTH=32).
module tb_hwpe_stream_source_realigner;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clear = 1'b0;
  logic        ctrl_start = 1'b0;
  logic [1:0]  ctrl_offset = '0;
  logic [15:0] ctrl_len = '0;
  logic        busy, done;
  logic        push_valid = 1'b0;
  logic        push_ready;
  logic [31:0] push_data = '0;
  logic [3:0]  push_strb = '0;
  logic        pop_valid;
  logic        pop_ready = 1'b0;
  logic [31:0] pop_data;
  logic [3:0]  pop_strb;

  int total = 0;
  int bad = 0;

  logic [31:0] in_words  [0:31];
  logic [31:0] exp_words [0:31];

  typedef struct {
    int          off;
    int          len;
    logic [31:0] iw [0:4];
    logic [31:0] ow [0:3];
  } vec_t;

  vec_t vt [6];

  always #5 clk = ~clk;

  hwpe_stream_source_realigner #(.DATA_WIDTH(32), .LEN_WIDTH(16)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .clear_i       (clear),
    .ctrl_start_i  (ctrl_start),
    .ctrl_offset_i (ctrl_offset),
    .ctrl_len_i    (ctrl_len),
    .flags_busy_o  (busy),
    .flags_done_o  (done),
    .push_valid_i  (push_valid),
    .push_ready_o  (push_ready),
    .push_data_i   (push_data),
    .push_strb_i   (push_strb),
    .pop_valid_o   (pop_valid),
    .pop_ready_i   (pop_ready),
    .pop_data_o    (pop_data),
    .pop_strb_o    (pop_strb)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Runs one transfer from in_words, checking every output against exp_words.
  task automatic run_xfer(input int off, input int len, input bit stall, input bit poke,
                          input string nm);
    int          nin;
    int          ip = 0;
    int          op = 0;
    int          cyc = 0;
    int          early_done = 0;
    bit          pend = 0;
    bit          prev_stall = 0;
    logic [31:0] prev_data = '0;
    nin = (off == 0) ? len : len + 1;
    ctrl_offset = 2'(off);
    ctrl_len    = 16'(len);
    ctrl_start  = 1'b1;
    push_valid  = 1'b0;
    pop_ready   = 1'b0;
    @(posedge clk); #1;
    ctrl_start = 1'b0;
    chk({nm, " busy"}, 32'(busy), 32'd1);
    while (op < len && cyc < 400) begin
      if (poke && cyc == 1) begin
        ctrl_start  = 1'b1;
        ctrl_len    = 16'd1;
        ctrl_offset = 2'd0;
      end else begin
        ctrl_start = 1'b0;
      end
      if (pend)           push_valid = 1'b1;
      else if (ip < nin)  push_valid = !stall || ($urandom_range(0, 4) != 0);
      else                push_valid = 1'b0;
      push_data = (ip < nin) ? in_words[ip] : 32'h0;
      pop_ready = !stall || ($urandom_range(0, 4) != 0);
      @(negedge clk);
      if (prev_stall) begin
        chk({nm, " stall-hold"}, {pop_valid, pop_data[30:0]}, {1'b1, prev_data[30:0]});
        chk({nm, " stall-msb"}, 32'(pop_data[31]), 32'(prev_data[31]));
      end
      if (pop_valid && pop_ready) begin
        chk($sformatf("%s out%0d", nm, op), pop_data, exp_words[op]);
        chk($sformatf("%s strb%0d", nm, op), 32'(pop_strb), 32'hF);
        op++;
      end
      prev_stall = pop_valid && !pop_ready;
      prev_data  = pop_data;
      pend       = push_valid && !push_ready;
      if (push_valid && push_ready) ip++;
      if (done) early_done++;
      @(posedge clk); #1;
      cyc++;
    end
    ctrl_start = 1'b0;
    push_valid = 1'b0;
    pop_ready  = 1'b0;
    #1;
    chk({nm, " outputs"}, 32'(op), 32'(len));
    chk({nm, " consumed"}, 32'(ip), 32'(nin));
    chk({nm, " early-done"}, 32'(early_done), 32'd0);
    chk({nm, " done"}, 32'(done), 32'd1);
    chk({nm, " busy-end"}, 32'(busy), 32'd0);
    @(posedge clk); #1;
    chk({nm, " done-drop"}, 32'(done), 32'd0);
    $display("xfer %s: off=%0d len=%0d outputs=%0d inputs=%0d cycles=%0d", nm, off, len, op, ip, cyc);
  endtask

  initial begin
    vt[0] = '{0, 3, '{32'hA0, 32'hA1, 32'hA2, 32'h0, 32'h0},
                    '{32'hA0, 32'hA1, 32'hA2, 32'h0}};
    vt[1] = '{1, 2, '{32'h33221100, 32'h77665544, 32'hBBAA9988, 32'h0, 32'h0},
                    '{32'h44332211, 32'h88776655, 32'h0, 32'h0}};
    vt[2] = '{2, 2, '{32'h33221100, 32'h77665544, 32'hBBAA9988, 32'h0, 32'h0},
                    '{32'h55443322, 32'h99887766, 32'h0, 32'h0}};
    vt[3] = '{3, 1, '{32'h33221100, 32'h77665544, 32'h0, 32'h0, 32'h0},
                    '{32'h66554433, 32'h0, 32'h0, 32'h0}};
    vt[4] = '{3, 3, '{32'h03020100, 32'h07060504, 32'h0B0A0908, 32'h0F0E0D0C, 32'h0},
                    '{32'h06050403, 32'h0A090807, 32'h0E0D0C0B, 32'h0}};
    vt[5] = '{2, 1, '{32'hDEADBEEF, 32'h12345678, 32'h0, 32'h0, 32'h0},
                    '{32'h5678DEAD, 32'h0, 32'h0, 32'h0}};

    // Reset state
    #12;
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst done", 32'(done), 32'd0);
    chk("rst pop_valid", 32'(pop_valid), 32'd0);
    chk("rst push_ready", 32'(push_ready), 32'd0);
    chk("rst pop_data", pop_data, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Table-driven transfers
    for (int i = 0; i < 6; i++) begin
      for (int k = 0; k < 5; k++) in_words[k] = vt[i].iw[k];
      for (int k = 0; k < 4; k++) exp_words[k] = vt[i].ow[k];
      run_xfer(vt[i].off, vt[i].len, 1'b0, 1'b0, $sformatf("vec%0d", i));
    end

    // Offset 3, len 16 with random stalls on both sides
    begin
      logic [7:0] bytes [0:71];
      for (int k = 0; k < 72; k++) bytes[k] = 8'((k * 37 + 5) & 8'hFF);
      for (int j = 0; j < 17; j++)
        in_words[j] = {bytes[4*j+3], bytes[4*j+2], bytes[4*j+1], bytes[4*j]};
      for (int j = 0; j < 16; j++)
        exp_words[j] = {bytes[4*j+6], bytes[4*j+5], bytes[4*j+4], bytes[4*j+3]};
      run_xfer(3, 16, 1'b1, 1'b0, "rand");
    end

    // Start pulsed while busy must not change the length
    for (int k = 0; k < 3; k++) begin
      in_words[k]  = 32'hC0 + 32'(k);
      exp_words[k] = 32'hC0 + 32'(k);
    end
    run_xfer(0, 3, 1'b0, 1'b1, "busy-start");

    // Zero length: no handshake, done one cycle later, busy stays low
    ctrl_start = 1'b1; ctrl_len = 16'd0; ctrl_offset = 2'd2;
    push_valid = 1'b1; pop_ready = 1'b1; push_data = 32'h12345678;
    @(negedge clk);
    chk("len0 push_ready", 32'(push_ready), 32'd0);
    chk("len0 pop_valid", 32'(pop_valid), 32'd0);
    @(posedge clk); #1;
    ctrl_start = 1'b0;
    chk("len0 done", 32'(done), 32'd1);
    chk("len0 busy", 32'(busy), 32'd0);
    chk("len0 push_ready2", 32'(push_ready), 32'd0);
    @(posedge clk); #1;
    chk("len0 done-drop", 32'(done), 32'd0);
    push_valid = 1'b0; pop_ready = 1'b0;
    $display("xfer len0: done pulse checked");

    // Clear during PRIME
    ctrl_start = 1'b1; ctrl_len = 16'd2; ctrl_offset = 2'd2;
    @(posedge clk); #1;
    ctrl_start = 1'b0;
    chk("clr prime busy", 32'(busy), 32'd1);
    chk("clr prime push_ready", 32'(push_ready), 32'd1);
    chk("clr prime pop_valid", 32'(pop_valid), 32'd0);
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    chk("clr busy", 32'(busy), 32'd0);
    chk("clr done", 32'(done), 32'd0);
    chk("clr push_ready", 32'(push_ready), 32'd0);
    @(posedge clk); #1;
    chk("clr done-late", 32'(done), 32'd0);
    $display("xfer clear-prime: returned to idle");

    // Clear together with start: start ignored
    ctrl_start = 1'b1; clear = 1'b1; ctrl_len = 16'd2; ctrl_offset = 2'd1;
    @(posedge clk); #1;
    ctrl_start = 1'b0; clear = 1'b0;
    chk("clr+start busy", 32'(busy), 32'd0);
    $display("xfer clear+start: start ignored");

    // Asynchronous reset after 2 of 5 outputs in STREAM
    ctrl_offset = 2'd1; ctrl_len = 16'd5; ctrl_start = 1'b1;
    push_valid = 1'b1; push_data = 32'h03020100; pop_ready = 1'b1;
    @(posedge clk); #1;
    ctrl_start = 1'b0;
    @(posedge clk); #1;
    push_data = 32'h07060504;
    #1;
    chk("rstm out0", pop_data, 32'h04030201);
    @(posedge clk); #1;
    push_data = 32'h0B0A0908;
    #1;
    chk("rstm out1", pop_data, 32'h08070605);
    @(posedge clk); #1;
    chk("rstm valid", 32'(pop_valid), 32'd1);
    rst = 1'b1;
    #1;
    chk("rstm pop_valid", 32'(pop_valid), 32'd0);
    chk("rstm busy", 32'(busy), 32'd0);
    chk("rstm push_ready", 32'(push_ready), 32'd0);
    chk("rstm pop_data", pop_data, 32'd0);
    chk("rstm done", 32'(done), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0; push_valid = 1'b0; pop_ready = 1'b0;
    @(posedge clk); #1;
    chk("rstm done-late", 32'(done), 32'd0);
    $display("xfer reset-mid-stream: aborted");
    for (int k = 0; k < 5; k++) in_words[k] = vt[5].iw[k];
    for (int k = 0; k < 4; k++) exp_words[k] = vt[5].ow[k];
    run_xfer(2, 1, 1'b0, 1'b0, "after-rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
